// File: rtl/featuremap_streamer_if.sv
// Host-facing bundle of the feature-map streamer: buffer write port, start control
// and the pixel stream toward the conv2d bank.
interface featuremap_streamer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_W     = 10
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  start;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  sof;
    logic                  eol;
    logic                  busy;
    logic                  done;
    logic                  wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  data_out, valid_out, sof, eol, busy, done, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output data_out, valid_out, sof, eol, busy, done, wr_drop
    );
endinterface

// File: rtl/featuremap_streamer.sv
// Frame buffer plus raster-order replay engine feeding a conv2d feature-map bank.
// One frame is held in a synchronous RAM and streamed on start, GAP idle cycles between beats.
module featuremap_streamer #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int GAP        = 0,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    featuremap_streamer_if.slave  bus
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GAP_W = $clog2(GAP + 2);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);
    localparam logic [GAP_W-1:0]  GAP_L    = GAP_W'(GAP);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     row;
    logic [ADDR_W-1:0]     col;
    logic [ADDR_W-1:0]     pix;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  wr_ok;
    logic                  issue;
    logic                  last_pix;

    // The host may only touch the buffer while no frame is being replayed.
    assign wr_ok    = !bus.busy && ({1'b0, bus.wr_addr} < DEPTH_L);
    assign issue    = (state == RUN) && (gap_cnt == '0);
    assign last_pix = (row == LAST_ROW) && (col == LAST_COL);

    // NOTE: the frame buffer has no reset; its contents are host data, and a reset
    // port would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_ok) begin
            mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            pix           <= '0;
            gap_cnt       <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.sof       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.wr_drop   <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.sof       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.done      <= 1'b0;
            bus.wr_drop   <= bus.wr_en && !wr_ok;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        row      <= '0;
                        col      <= '0;
                        pix      <= '0;
                        gap_cnt  <= '0;
                    end
                end

                RUN: begin
                    if (issue) begin
                        // Read data lands directly in the output register: one-cycle latency.
                        bus.data_out  <= mem[pix[IDX_W-1:0]];
                        bus.valid_out <= 1'b1;
                        bus.sof       <= (pix == '0);
                        bus.eol       <= (col == LAST_COL);
                        gap_cnt       <= GAP_L;
                        if (last_pix) begin
                            state <= FLUSH;
                        end else begin
                            pix <= pix + 1'b1;
                            if (col == LAST_COL) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                FLUSH: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    row      <= '0;
                    col      <= '0;
                    pix      <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_featuremap_streamer.sv
// Directed bench for featuremap_streamer on a 4x3 frame, one instance with GAP=0 and
// one with GAP=2; expected waveforms are derived from the cycle numbering of the frame.
module tb_featuremap_streamer;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    featuremap_streamer_if #(.DATA_WIDTH(24), .ADDR_W(10)) f0 ();
    featuremap_streamer_if #(.DATA_WIDTH(24), .ADDR_W(10)) f2 ();

    featuremap_streamer #(
        .DATA_WIDTH(24), .IMG_W(4), .IMG_H(3), .GAP(0), .ADDR_W(10)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (f0.slave)
    );

    featuremap_streamer #(
        .DATA_WIDTH(24), .IMG_W(4), .IMG_H(3), .GAP(2), .ADDR_W(10)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (f2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {valid_out, sof, eol, busy, done, wr_drop}
    function automatic logic [5:0] flags0();
        return {f0.valid_out, f0.sof, f0.eol, f0.busy, f0.done, f0.wr_drop};
    endfunction

    function automatic logic [5:0] flags2();
        return {f2.valid_out, f2.sof, f2.eol, f2.busy, f2.done, f2.wr_drop};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f0.wr_en = 1'($urandom); f0.wr_addr = 10'($urandom); f0.wr_data = 24'($urandom);
            f0.start = 1'($urandom);
            f2.wr_en = 1'($urandom); f2.wr_addr = 10'($urandom); f2.wr_data = 24'($urandom);
            f2.start = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (flags0() !== 6'b0 || f0.data_out !== 24'd0 || flags2() !== 6'b0 || f2.data_out !== 24'd0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: flags0=%b data0=%h flags2=%b data2=%h, want all 0",
                         i, flags0(), f0.data_out, flags2(), f2.data_out);
            end
            next_cycle();
        end
        f0.wr_en = 1'b0; f0.wr_addr = '0; f0.wr_data = '0; f0.start = 1'b0;
        f2.wr_en = 1'b0; f2.wr_addr = '0; f2.wr_data = '0; f2.start = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (flags0() !== 6'b0 || f0.data_out !== 24'd0 || flags2() !== 6'b0 || f2.data_out !== 24'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: flags0=%b data0=%h flags2=%b data2=%h, want all 0",
                         i, flags0(), f0.data_out, flags2(), f2.data_out);
            end
            next_cycle();
        end
    endtask

    // Loads pixel = index into both buffers.
    task automatic test_load();
        for (int i = 0; i < 12; i++) begin
            f0.wr_en = 1'b1; f0.wr_addr = 10'(i); f0.wr_data = 24'(i);
            f2.wr_en = 1'b1; f2.wr_addr = 10'(i); f2.wr_data = 24'(i);
            next_cycle();
        end
        f0.wr_en = 1'b0;
        f2.wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (f0.wr_drop !== 1'b0 || f2.wr_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL load_no_drop: wr_drop0=%b wr_drop2=%b, want 0", f0.wr_drop, f2.wr_drop);
        end
        next_cycle();
    endtask

    // One GAP=0 frame started in cycle 0. drop_cyc >= 0 injects a write (addr 5) while busy;
    // wr0 writes pixel 0 = 'h55 in the same cycle as start.
    task automatic stream_frame(input string name, input logic [23:0] prev, input int drop_cyc, input bit wr0);
        logic [5:0]  exp_f;
        logic [23:0] exp_d;
        int          p;
        f0.start = 1'b1;
        if (wr0) begin
            f0.wr_en = 1'b1; f0.wr_addr = 10'd0; f0.wr_data = 24'h55;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            p = c - 2;
            exp_f = {(c >= 2 && c <= 13), (c == 2), (c == 5 || c == 9 || c == 13),
                     (c >= 1 && c <= 13), (c == 14), (drop_cyc >= 0 && c == drop_cyc + 1)};
            if (c < 2)       exp_d = prev;
            else if (c > 13) exp_d = 24'd11;
            else             exp_d = (p == 0 && wr0) ? 24'h55 : 24'(p);
            vectors++;
            if (flags0() !== exp_f) begin
                miscompares++;
                $display("FAIL %s flags cycle %0d: got %b want %b", name, c, flags0(), exp_f);
            end
            vectors++;
            if (f0.data_out !== exp_d) begin
                miscompares++;
                $display("FAIL %s data cycle %0d: got %h want %h", name, c, f0.data_out, exp_d);
            end
            next_cycle();
            f0.start = 1'b0;
            f0.wr_en = 1'b0;
            if (c + 1 == drop_cyc) begin
                f0.wr_en = 1'b1; f0.wr_addr = 10'd5; f0.wr_data = 24'hAA;
            end
        end
    endtask

    task automatic test_stream();
        stream_frame("stream", 24'd0, -1, 1'b0);
    endtask

    task automatic test_write_with_start();
        stream_frame("wr_with_start", 24'd11, -1, 1'b1);
        f0.wr_en = 1'b1; f0.wr_addr = 10'd0; f0.wr_data = 24'd0;
        next_cycle();
        f0.wr_en = 1'b0;
    endtask

    task automatic test_write_drop();
        f0.wr_en = 1'b1; f0.wr_addr = 10'd12; f0.wr_data = 24'hFFFFFF;
        @(negedge clk);
        vectors++;
        if (f0.wr_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_range_early: wr_drop=%b want 0", f0.wr_drop);
        end
        next_cycle();
        f0.wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (f0.wr_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_range_pulse: wr_drop=%b want 1", f0.wr_drop);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (f0.wr_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_range_clear: wr_drop=%b want 0", f0.wr_drop);
        end
        next_cycle();
        stream_frame("drop_busy", 24'd11, 3, 1'b0);
        stream_frame("after_drop", 24'd11, -1, 1'b0);
    endtask

    task automatic test_gap();
        logic [5:0]  exp_f;
        logic [23:0] exp_d;
        bit          v;
        int          k;
        int          beats;
        beats = 0;
        f2.start = 1'b1;
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            k = (c >= 2) ? (c - 2) / 3 : 0;
            v = (c >= 2 && c <= 35 && ((c - 2) % 3) == 0);
            exp_f = {v, (c == 2), (v && (k % 4) == 3), (c >= 1 && c <= 35), (c == 36), 1'b0};
            if (c < 2)       exp_d = 24'd0;
            else if (c > 35) exp_d = 24'd11;
            else             exp_d = 24'(k);
            if (f2.valid_out === 1'b1) beats++;
            vectors++;
            if (flags2() !== exp_f) begin
                miscompares++;
                $display("FAIL gap flags cycle %0d: got %b want %b", c, flags2(), exp_f);
            end
            vectors++;
            if (f2.data_out !== exp_d) begin
                miscompares++;
                $display("FAIL gap data cycle %0d: got %h want %h", c, f2.data_out, exp_d);
            end
            next_cycle();
            f2.start = 1'b0;
        end
        vectors++;
        if (beats != 12) begin
            miscompares++;
            $display("FAIL gap_beats: got %0d want 12", beats);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  exp_f;
        int          t;
        int          beats;
        int          dones;
        bit          v;
        beats = 0;
        dones = 0;
        f0.start = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            t = c % 14;
            v = (c < 42) && (t >= 2);
            exp_f = {v, (v && t == 2), (v && ((t - 2) % 4) == 3), (c < 42 && t >= 1),
                     (c == 14 || c == 28 || c == 42), 1'b0};
            if (f0.valid_out === 1'b1) beats++;
            if (f0.done === 1'b1) dones++;
            vectors++;
            if (flags0() !== exp_f) begin
                miscompares++;
                $display("FAIL b2b flags cycle %0d: got %b want %b", c, flags0(), exp_f);
            end
            if (v) begin
                vectors++;
                if (f0.data_out !== 24'(t - 2)) begin
                    miscompares++;
                    $display("FAIL b2b data cycle %0d: got %h want %h", c, f0.data_out, 24'(t - 2));
                end
            end
            next_cycle();
            if (c == 28) f0.start = 1'b0;
        end
        vectors++;
        if (beats != 36 || dones != 3) begin
            miscompares++;
            $display("FAIL b2b_counts: beats=%0d dones=%0d want 36 and 3", beats, dones);
        end

        beats = 0;
        dones = 0;
        f0.start = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (f0.valid_out === 1'b1) beats++;
            if (f0.done === 1'b1) dones++;
            next_cycle();
            f0.start = (c + 1 == 5) ? 1'b1 : 1'b0;
        end
        vectors++;
        if (beats != 12 || dones != 1) begin
            miscompares++;
            $display("FAIL start_ignored: beats=%0d dones=%0d want 12 and 1", beats, dones);
        end
    endtask

    task automatic test_reset_mid();
        f0.start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                vectors++;
                if (f0.valid_out !== 1'b1 || f0.data_out !== 24'd3) begin
                    miscompares++;
                    $display("FAIL reset_mid_pre: valid=%b data=%h want 1 and 000003", f0.valid_out, f0.data_out);
                end
            end
            next_cycle();
            f0.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (flags0() !== 6'b0 || f0.data_out !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_mid_same_cycle: flags=%b data=%h want all 0", flags0(), f0.data_out);
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++;
            if (f0.done !== 1'b0 || f0.busy !== 1'b0 || f0.valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet cycle %0d: done=%b busy=%b valid=%b want 0",
                         c, f0.done, f0.busy, f0.valid_out);
            end
            next_cycle();
        end
        stream_frame("after_reset", 24'd0, -1, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        f0.wr_en = 1'b0; f0.wr_addr = '0; f0.wr_data = '0; f0.start = 1'b0;
        f2.wr_en = 1'b0; f2.wr_addr = '0; f2.wr_data = '0; f2.start = 1'b0;
        next_cycle();

        test_reset();
        test_load();
        test_stream();
        test_write_with_start();
        test_write_drop();
        test_gap();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
